mul_div_unit: RTL and testbench

Iterative multi-cycle multiply/divide unit for the pipelined CPU. It executes MUL, DIVU and REMU off the single-cycle ALU path, using one shift-add or restoring-subtract step per cycle. It sits beside the ALU in EX. It uses the ALU's 3-bit control encoding for MUL and extends it with divide codes. The hazard unit holds IF/ID/EX while `busy_o` is high.

---
 rtl/mul_div_unit_pkg.sv | 21 ++
 rtl/mul_div_unit_if.sv | 27 ++
 rtl/mul_div_unit_step.sv | 42 ++++
 rtl/mul_div_unit.sv | 147 ++++++++++++++
 tb/tb_mul_div_unit.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared opcode constants and FSM state type for the iterative multiply/divide unit.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package muldiv_pkg;

    // Opcodes reuse the ALU 3-bit control encoding; divide codes extend it.
    localparam logic [2:0] MULDIV_OP_MUL  = 3'b101;
    localparam logic [2:0] MULDIV_OP_DIVU = 3'b011;
    localparam logic [2:0] MULDIV_OP_REMU = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } muldiv_state_t;

    function automatic logic op_supported(input logic [2:0] op);
        return (op == MULDIV_OP_MUL) || (op == MULDIV_OP_DIVU) || (op == MULDIV_OP_REMU);
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
// Latency: n/a (wiring only).
// Backpressure: none; the requester watches busy_o and done_o.
interface mul_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic [2:0]       op_i;
    logic [WIDTH-1:0] data1_i;
    logic [WIDTH-1:0] data2_i;
    logic             flush_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] data_o;

    // Requester side (pipeline / testbench)
    modport master (
        output start_i, op_i, data1_i, data2_i, flush_i,
        input  busy_o, done_o, data_o
    );

    // Unit side
    modport slave (
        input  start_i, op_i, data1_i, data2_i, flush_i,
        output busy_o, done_o, data_o
    );
endinterface

// File: rtl/mul_div_unit_step.sv
// One iteration of shift-add multiply or restoring divide on a 2*WIDTH accumulator.
// Latency: purely combinational.
// Backpressure: none.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic               i_is_mul,
    input  logic [2*WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0]   i_opnd,
    output logic [2*WIDTH-1:0] o_acc,
    output logic               o_qbit
);
    // MUL: acc = {upper, multiplier remaining}; the add keeps its carry so the
    // right shift never loses a product bit.
    logic [WIDTH:0]   w_addend;
    logic [WIDTH:0]   w_sum;
    // DIV: acc = {remainder, dividend bits still to shift in / quotient bits}.
    // The compare is WIDTH+1 bits wide so the shifted-out remainder MSB counts.
    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_diff;
    logic             w_ge;

    assign w_addend = i_acc[0] ? {1'b0, i_opnd} : '0;
    assign w_sum    = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + w_addend;
    assign w_shift  = {i_acc[2*WIDTH-1:WIDTH], i_acc[WIDTH-1]};
    assign w_ge     = (w_shift >= {1'b0, i_opnd});
    // When w_ge holds the true difference is below the divisor, so WIDTH bits suffice.
    assign w_diff   = w_shift[WIDTH-1:0] - i_opnd;

    // Select the multiply or divide iteration result.
    always_comb begin
        o_acc  = '0;
        o_qbit = 1'b0;
        if (i_is_mul) begin
            o_acc = {w_sum, i_acc[WIDTH-1:1]};
        end else begin
            o_acc  = {(w_ge ? w_diff : w_shift[WIDTH-1:0]), i_acc[WIDTH-2:0], w_ge};
            o_qbit = w_ge;
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MUL/DIVU/REMU unit beside the ALU; one shift-add or restoring-subtract step per cycle.
// Latency: WIDTH+1 cycles start-to-done (1 cycle for unsupported ops, and for zero operands when MULDIV_EARLY_OUT_EN is defined).
// Backpressure: busy_o holds the pipeline; start_i is only accepted in IDLE/DONE, flush_i aborts.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input logic             clk_i,
    input logic             rst_i,
    mul_div_unit_if.slave   bus
);
    import muldiv_pkg::*;

    localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    muldiv_state_t      r_state;
    muldiv_state_t      w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opnd;
    logic [2:0]         r_op;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_data;

    logic               w_supported;
    logic               w_early;
    logic               w_direct;
    logic               w_accept;
    logic               w_last;
    logic               w_finish;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic [WIDTH-1:0]   w_direct_res;
    logic [2*WIDTH-1:0] w_step_acc;
    logic               w_step_qbit;
    logic [WIDTH-1:0]   w_step_res;

    assign w_supported = op_supported(bus.op_i);

`ifdef MULDIV_EARLY_OUT_EN
    // Zero operands have a known answer, so skip the iteration entirely.
    assign w_early = ((bus.op_i == MULDIV_OP_MUL) && ((bus.data1_i == '0) || (bus.data2_i == '0)))
                  || (((bus.op_i == MULDIV_OP_DIVU) || (bus.op_i == MULDIV_OP_REMU)) && (bus.data2_i == '0));
`else
    assign w_early = 1'b0;
`endif

    // Direct ops complete at the accept edge without entering RUN.
    assign w_direct = !w_supported || w_early;
    // Flush wins over a start offered in DONE.
    assign w_accept = bus.start_i && ((r_state == ST_IDLE) || ((r_state == ST_DONE) && !bus.flush_i));
    assign w_last   = (r_cnt == CNT_LAST);

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_nxt = w_direct ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                if (bus.flush_i)  w_state_nxt = ST_IDLE;
                else if (w_last)  w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (w_accept) w_state_nxt = w_direct ? ST_DONE : ST_RUN;
                else          w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs; a flush on the final step eats the done pulse.
    always_comb begin
        w_finish   = (r_state == ST_RUN) && !bus.flush_i && w_last;
        w_busy_nxt = (w_state_nxt == ST_RUN);
        w_done_nxt = w_finish || (w_accept && w_direct);
    end

    // Result for ops that skip the iteration: zero for MUL/unsupported, divide-by-zero values otherwise.
    always_comb begin
        w_direct_res = '0;
        if (w_supported) begin
            if (bus.op_i == MULDIV_OP_DIVU)      w_direct_res = '1;
            else if (bus.op_i == MULDIV_OP_REMU) w_direct_res = bus.data1_i;
        end
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .i_is_mul (r_op == MULDIV_OP_MUL),
        .i_acc    (r_acc),
        .i_opnd   (r_opnd),
        .o_acc    (w_step_acc),
        .o_qbit   (w_step_qbit)
    );

    // Pick the product, quotient or remainder out of the final step.
    always_comb begin
        w_step_res = w_step_acc[WIDTH-1:0];
        if (r_op == MULDIV_OP_REMU)      w_step_res = w_step_acc[2*WIDTH-1:WIDTH];
        else if (r_op == MULDIV_OP_DIVU) w_step_res = {w_step_acc[WIDTH-1:1], w_step_qbit};
    end

    // Operand capture, iteration counter, accumulator and result registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cnt  <= '0;
            r_acc  <= '0;
            r_opnd <= '0;
            r_op   <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_data <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
            if (w_accept) begin
                r_op  <= bus.op_i;
                r_cnt <= '0;
                if (bus.op_i == MULDIV_OP_MUL) begin
                    r_acc  <= {{WIDTH{1'b0}}, bus.data2_i};
                    r_opnd <= bus.data1_i;
                end else begin
                    r_acc  <= {{WIDTH{1'b0}}, bus.data1_i};
                    r_opnd <= bus.data2_i;
                end
                if (w_direct) r_data <= w_direct_res;
            end else if (r_state == ST_RUN) begin
                r_cnt <= r_cnt + CNT_W'(1);
                r_acc <= w_step_acc;
                if (w_finish) r_data <= w_step_res;
            end
        end
    end

    assign bus.busy_o = r_busy;
    assign bus.done_o = r_done;
    assign bus.data_o = r_data;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: vector table, random ops against a reference model, corner sequences.
// Latency: checks WIDTH+1 full-latency path and the 1-cycle direct path.
// Backpressure: exercises start during RUN, start during DONE, flush and mid-op reset.
module tb_mul_div_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    mul_div_unit_if #(.WIDTH(W)) bus ();

    mul_div_unit #(.WIDTH(W)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [11];

    // Reference: plain arithmetic with the unit's divide-by-zero conventions.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        case (op)
            MULDIV_OP_MUL:  return p[31:0];
            MULDIV_OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            MULDIV_OP_REMU: return (b == 0) ? a : a % b;
            default:        return 32'd0;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (!(op == MULDIV_OP_MUL || op == MULDIV_OP_DIVU || op == MULDIV_OP_REMU)) return 1;
`ifdef MULDIV_EARLY_OUT_EN
        if (op == MULDIV_OP_MUL && (a == 0 || b == 0)) return 1;
        if (op != MULDIV_OP_MUL && b == 0) return 1;
`endif
        return W + 1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.data1_i = a;
        bus.data2_i = b;
    endtask

    // Count negedges from the accepting edge until done_o; optionally re-pulse start at cycle pulse_at.
    task automatic wait_done(input int pulse_at, output logic [31:0] res, output int lat, output int busy_n);
        bit seen;
        seen   = 0;
        res    = '0;
        lat    = -1;
        busy_n = 0;
        for (int c = 1; c <= 100 && !seen; c++) begin
            @(negedge clk);
            if (c == pulse_at) launch(MULDIV_OP_DIVU, 32'd77, 32'd5);
            else               bus.start_i = 1'b0;
            if (bus.busy_o) busy_n++;
            if (bus.done_o) begin
                res  = bus.data_o;
                lat  = c;
                seen = 1;
            end
        end
        bus.start_i = 1'b0;
    endtask

    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output int busy_n);
        @(negedge clk);
        launch(op, a, b);
        wait_done(0, res, lat, busy_n);
    endtask

    initial begin
        logic [31:0] res;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [2:0]  eop;
        logic [31:0] prev;
        int          lat;
        int          busy_n;
        int          el;
        int          done_cnt;
        logic [2:0]  ops [3];

        n_vec = 0;
        n_err = 0;
        ops[0] = MULDIV_OP_MUL;
        ops[1] = MULDIV_OP_DIVU;
        ops[2] = MULDIV_OP_REMU;

        tbl[0]  = '{MULDIV_OP_MUL,  32'd7,          32'd6,          32'd42};
        tbl[1]  = '{MULDIV_OP_MUL,  32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFE};
        tbl[2]  = '{MULDIV_OP_DIVU, 32'd100,        32'd7,          32'd14};
        tbl[3]  = '{MULDIV_OP_REMU, 32'd100,        32'd7,          32'd2};
        tbl[4]  = '{MULDIV_OP_DIVU, 32'h8000_0000,  32'd1,          32'h8000_0000};
        tbl[5]  = '{MULDIV_OP_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF};
        tbl[6]  = '{MULDIV_OP_REMU, 32'd5,          32'd0,          32'd5};
        tbl[7]  = '{3'b000,         32'd9,          32'd3,          32'd0};
        tbl[8]  = '{MULDIV_OP_MUL,  32'h1234_5678,  32'd0,          32'd0};
        tbl[9]  = '{MULDIV_OP_MUL,  32'h0001_0000,  32'h0001_0000,  32'd0};
        tbl[10] = '{MULDIV_OP_REMU, 32'hFFFF_FFFF,  32'h8000_0001,  32'h7FFF_FFFE};

        rst_n       = 1'b0;
        bus.start_i = 1'b0;
        bus.op_i    = '0;
        bus.data1_i = '0;
        bus.data2_i = '0;
        bus.flush_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset busy", 32'(bus.busy_o), 32'd0);
        chk("reset done", 32'(bus.done_o), 32'd0);
        chk("reset data", bus.data_o, 32'd0);
        rst_n = 1'b1;

        // Vector table
        for (int i = 0; i < 11; i++) begin
            do_op(tbl[i].op, tbl[i].a, tbl[i].b, res, lat, busy_n);
            el = exp_lat(tbl[i].op, tbl[i].a, tbl[i].b);
            chk($sformatf("vec%0d data", i), res, tbl[i].exp);
            chk($sformatf("vec%0d latency", i), 32'(lat), 32'(el));
            chk($sformatf("vec%0d busy cycles", i), 32'(busy_n), (el == 1) ? 32'd0 : 32'(W));
        end

        // Randomized ops against the reference model
        for (int i = 0; i < 30; i++) begin
            eop = ops[$urandom_range(0, 2)];
            ea  = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
            case ($urandom_range(0, 5))
                0:       eb = 32'd0;
                1, 2:    eb = 32'($urandom_range(1, 20));
                default: eb = $urandom;
            endcase
            do_op(eop, ea, eb, res, lat, busy_n);
            chk($sformatf("rnd%0d op%b %h,%h data", i, eop, ea, eb), res, model(eop, ea, eb));
            chk($sformatf("rnd%0d latency", i), 32'(lat), 32'(exp_lat(eop, ea, eb)));
        end

        // Start during RUN is ignored
        @(negedge clk);
        launch(MULDIV_OP_MUL, 32'd3, 32'd3);
        wait_done(10, res, lat, busy_n);
        chk("start in RUN data", res, 32'd9);
        chk("start in RUN latency", 32'(lat), 32'(W + 1));

        // Back-to-back: start offered in the DONE cycle is accepted
        do_op(MULDIV_OP_MUL, 32'd7, 32'd6, res, lat, busy_n);
        chk("b2b first data", res, 32'd42);
        launch(MULDIV_OP_DIVU, 32'd100, 32'd7);
        wait_done(0, res, lat, busy_n);
        chk("b2b second data", res, 32'd14);
        chk("b2b second latency", 32'(lat), 32'(W + 1));

        // Flush mid-DIVU: no done, busy drops, data_o held
        do_op(MULDIV_OP_MUL, 32'd11, 32'd12, res, lat, busy_n);
        prev = model(MULDIV_OP_MUL, 32'd11, 32'd12);
        chk("pre-flush data", res, prev);
        @(negedge clk);
        launch(MULDIV_OP_DIVU, 32'd1000, 32'd3);
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            bus.start_i = 1'b0;
        end
        chk("busy before flush", 32'(bus.busy_o), 32'd1);
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        chk("busy after flush", 32'(bus.busy_o), 32'd0);
        done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.done_o) done_cnt++;
            @(negedge clk);
        end
        chk("done after flush", 32'(done_cnt), 32'd0);
        chk("data after flush", bus.data_o, prev);

        // Reset mid-operation clears everything immediately
        @(negedge clk);
        launch(MULDIV_OP_MUL, 32'd9, 32'd9);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            bus.start_i = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        chk("mid reset busy", 32'(bus.busy_o), 32'd0);
        chk("mid reset done", 32'(bus.done_o), 32'd0);
        chk("mid reset data", bus.data_o, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_op(MULDIV_OP_DIVU, 32'd100, 32'd7, res, lat, busy_n);
        chk("post reset data", res, 32'd14);
        chk("post reset latency", 32'(lat), 32'(W + 1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
